serial_adder_resp: RTL

- Bit-serial, handshaked adder. It answers the same operand/result contract as the 4-bit carry-lookahead adder: {Cout,S} = X + Y + Cin.
- It computes one bit per clock with a single full adder and a carry flip-flop, LSB first.
- It serves as the area-optimised responder on the arithmetic request path. It can swap in for the combinational adder wherever a Start/Done handshake is acceptable.

---
 rtl/serial_adder_resp.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_adder_resp.sv
// Bit-serial handshaked adder: {Cout,S} = X + Y + Cin, one full adder, LSB first, WIDTH+1 edges to Done.
// Optional SERIAL_ADDER_SUB_EN adds a Sub port computing X + ~Y + 1 (Cout=1 means no borrow).
module serial_adder_resp #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, y_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, busy_q, done_q;
  logic             busy_d, done_d;
  logic             accept, last_shift;
  logic             y_bit, sum_bit, carry_bit;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  assign y_bit = y_q[0] ^ sub_q;
`else
  assign y_bit = y_q[0];
`endif

  assign sum_bit    = x_q[0] ^ y_bit ^ c_q;
  assign carry_bit  = (x_q[0] & y_bit) | (x_q[0] & c_q) | (y_bit & c_q);
  assign accept     = (state_q == IDLE) && Start;
  assign last_shift = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Busy/Done are decoded from the next state so they can be registered.
  always_comb begin
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      s_q    <= '0;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else if (accept) begin
      x_q   <= X;
      y_q   <= Y;
      cnt_q <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q <= Sub;
      c_q   <= Sub ? 1'b1 : Cin;
`else
      c_q   <= Cin;
`endif
    end else if (state_q == SHIFT) begin
      x_q   <= x_q >> 1;
      y_q   <= y_q >> 1;
      s_q   <= {sum_bit, s_q[WIDTH-1:1]};
      c_q   <= carry_bit;
      cnt_q <= cnt_q + CW'(1);
      if (last_shift) cout_q <= carry_bit;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;

endmodule
